// File: rtl/moore_seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1111001 sequence detectors. A one-word holding
// register in front of the shifter lets back-to-back words go out with no idle bit between them.
module moore_seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             busy,
  output logic             frame_start
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             x_reg, x_next;
  logic             busy_reg, busy_next;
  logic             frame_start_reg, frame_start_next;

  // Held word rearranged so that bit WIDTH-1 is always the next bit to transmit;
  // the shifter then only ever shifts left, whatever the configured bit order.
  logic [WIDTH-1:0] hold_ordered;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign hold_ordered[gi] = hold_reg[gi];
      end else begin : g_lsb
        assign hold_ordered[gi] = hold_reg[WIDTH-1-gi];
      end
    end
  endgenerate

  logic accept;
  logic at_last_bit;

  assign accept      = in_valid & ~hold_full_reg;
  assign at_last_bit = (cnt_reg == LAST_CNT);

  always_comb begin
    state_next       = state_reg;
    hold_next        = hold_reg;
    hold_full_next   = hold_full_reg;
    shift_next       = shift_reg;
    cnt_next         = cnt_reg;
    x_next           = x_reg;
    busy_next        = busy_reg;
    frame_start_next = 1'b0;

    // Accept and load are mutually exclusive: accept needs the hold empty, load needs it full.
    if (accept) begin
      hold_next      = in_data;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        x_next    = IDLE_BIT;
        busy_next = 1'b0;
        cnt_next  = '0;
        if (hold_full_reg) begin
          state_next       = SHIFT;
          shift_next       = {hold_ordered[WIDTH-2:0], 1'b0};
          x_next           = hold_ordered[WIDTH-1];
          cnt_next         = '0;
          busy_next        = 1'b1;
          frame_start_next = 1'b1;
          hold_full_next   = 1'b0;
        end
      end

      SHIFT: begin
        if (at_last_bit) begin
          if (hold_full_reg) begin
            // Gapless reload: the next word's first bit directly follows the last bit.
            state_next       = SHIFT;
            shift_next       = {hold_ordered[WIDTH-2:0], 1'b0};
            x_next           = hold_ordered[WIDTH-1];
            cnt_next         = '0;
            busy_next        = 1'b1;
            frame_start_next = 1'b1;
            hold_full_next   = 1'b0;
          end else begin
            state_next = IDLE;
            x_next     = IDLE_BIT;
            busy_next  = 1'b0;
            cnt_next   = '0;
          end
        end else begin
          x_next     = shift_reg[WIDTH-1];
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt_reg + 1'b1;
          busy_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        x_next     = IDLE_BIT;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      hold_reg        <= '0;
      hold_full_reg   <= 1'b0;
      shift_reg       <= '0;
      cnt_reg         <= '0;
      x_reg           <= IDLE_BIT;
      busy_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_reg        <= hold_next;
      hold_full_reg   <= hold_full_next;
      shift_reg       <= shift_next;
      cnt_reg         <= cnt_next;
      x_reg           <= x_next;
      busy_reg        <= busy_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign in_ready    = ~hold_full_reg;
  assign x           = x_reg;
  assign busy        = busy_reg;
  assign frame_start = frame_start_reg;

endmodule
